// File: rtl/vx_tex_pkg.sv
// Shared texture-path constants and the round-robin pick helper used by response arbiters.
package vx_tex_pkg;
  localparam int TEX_TEXEL_BITS = 32;
  localparam int TEX_MAX_REQS   = 32;

  // Returns the first requesting index at or after ptr (wrapping modulo n), or -1 if none.
  function automatic int rr_pick(input logic [TEX_MAX_REQS-1:0] req, input int ptr, input int n);
    int idx;
    int win;
    win = -1;
    for (int i = TEX_MAX_REQS - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[$clog2(TEX_MAX_REQS)-1:0]]) win = idx;
      end
    end
    return win;
  endfunction
endpackage

// File: rtl/vx_tex_rsp_arb_if.sv
// Multi-source texture response bundle in, single merged response out.
interface vx_tex_rsp_arb_if
  import vx_tex_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 16
) ();
  localparam int SEL_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0;
  localparam int TAG_OUT_W = TAG_WIDTH + SEL_BITS;

  logic [NUM_REQS-1:0]                                  rsp_valid_in;
  logic [NUM_REQS-1:0][NUM_LANES-1:0][TEX_TEXEL_BITS-1:0] rsp_texels_in;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]                   rsp_tag_in;
  logic [NUM_REQS-1:0]                                  rsp_ready_in;
  logic                                                 rsp_valid_out;
  logic [NUM_LANES-1:0][TEX_TEXEL_BITS-1:0]             rsp_texels_out;
  logic [TAG_OUT_W-1:0]                                 rsp_tag_out;
  logic                                                 rsp_ready_out;

  modport master (
    output rsp_valid_in, rsp_texels_in, rsp_tag_in, rsp_ready_out,
    input  rsp_ready_in, rsp_valid_out, rsp_texels_out, rsp_tag_out
  );
  modport slave (
    input  rsp_valid_in, rsp_texels_in, rsp_tag_in, rsp_ready_out,
    output rsp_ready_in, rsp_valid_out, rsp_texels_out, rsp_tag_out
  );
endinterface

// File: rtl/vx_tex_skid_buf.sv
// Two-entry elastic buffer (main + skid); input ready comes from a register, never from out_ready.
module vx_tex_skid_buf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             full,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready
);
  logic             main_vld, skid_vld;
  logic [DATAW-1:0] main_q, skid_q;
  logic             in_fire, out_fire;

  assign in_fire   = in_valid & ~skid_vld;
  assign out_fire  = main_vld & out_ready;
  assign full      = skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_q;

  // Skid is only ever occupied while main is, so an empty main implies an empty skid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (!main_vld || out_fire) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end else if (in_fire) begin
        main_q <= in_data;
      end
      main_vld <= skid_vld | in_fire;
    end else if (in_fire) begin
      skid_q   <= in_data;
      skid_vld <= 1'b1;
    end
  end
endmodule

// File: rtl/vx_tex_rsp_arb.sv
// Round-robin merge of NUM_REQS texture response streams; winner index is prepended to the tag.
module vx_tex_rsp_arb
  import vx_tex_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 16
) (
  input logic             clk,
  input logic             reset,
  vx_tex_rsp_arb_if.slave bus
);
  localparam int SEL_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0;
  localparam int TAG_OUT_W = TAG_WIDTH + SEL_BITS;

  typedef struct packed {
    logic [NUM_LANES-1:0][TEX_TEXEL_BITS-1:0] texels;
    logic [TAG_OUT_W-1:0]                     tag;
  } tex_rsp_t;

  logic [NUM_REQS-1:0] grant;
  logic                in_valid, in_ready, in_fire, buf_full;
  tex_rsp_t            in_data, out_data;

  // Gating with reset keeps upstream from seeing ready while reset is held.
  assign in_ready         = ~buf_full & reset;
  assign in_valid         = |grant;
  assign in_fire          = in_valid & in_ready;
  assign bus.rsp_ready_in = grant & {NUM_REQS{in_ready}};

  generate
    if (NUM_REQS > 1) begin : g_arb
      logic [SEL_BITS-1:0] ptr, sel;
      int                  win;

      always_comb begin
        win   = rr_pick(TEX_MAX_REQS'(bus.rsp_valid_in), int'(ptr), NUM_REQS);
        sel   = '0;
        grant = '0;
        if (win >= 0) begin
          sel        = SEL_BITS'(win);
          grant[sel] = 1'b1;
        end
      end

      // Pointer only moves on an accepted transfer, so a stalled grant stays put.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)       ptr <= '0;
        else if (in_fire) ptr <= (sel == SEL_BITS'(NUM_REQS - 1)) ? '0 : sel + 1'b1;
      end

      assign in_data.tag    = {sel, bus.rsp_tag_in[sel]};
      assign in_data.texels = bus.rsp_texels_in[sel];
    end else begin : g_single
      assign grant          = bus.rsp_valid_in;
      assign in_data.tag    = bus.rsp_tag_in[0];
      assign in_data.texels = bus.rsp_texels_in[0];
    end
  endgenerate

  vx_tex_skid_buf #(.DATAW($bits(tex_rsp_t))) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .full      (buf_full),
    .out_valid (bus.rsp_valid_out),
    .out_data  (out_data),
    .out_ready (bus.rsp_ready_out)
  );

  assign bus.rsp_texels_out = out_data.texels;
  assign bus.rsp_tag_out    = out_data.tag;

`ifndef SYNTHESIS
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_chk
    a_hold: assert property (@(posedge clk) disable iff (!reset)
      bus.rsp_valid_in[i] && !bus.rsp_ready_in[i] |=>
        bus.rsp_valid_in[i] && $stable(bus.rsp_tag_in[i]) && $stable(bus.rsp_texels_in[i]));
  end
`endif
endmodule

// File: tb/tb_vx_tex_rsp_arb.sv
// Directed vector table for the 4-source arbiter plus reset and NUM_REQS=1 scoreboard sequences.
module tb_vx_tex_rsp_arb;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vx_tex_rsp_arb_if #(.NUM_REQS(4), .NUM_LANES(4), .TAG_WIDTH(16)) bus ();
  vx_tex_rsp_arb_if #(.NUM_REQS(1), .NUM_LANES(4), .TAG_WIDTH(16)) bus1 ();

  vx_tex_rsp_arb #(.NUM_REQS(4), .NUM_LANES(4), .TAG_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  vx_tex_rsp_arb #(.NUM_REQS(1), .NUM_LANES(4), .TAG_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [3:0] v;
    logic       r;
    logic       evld;
    int         esrc;
    logic [3:0] erdy;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic [3:0] v, logic r, logic evld, int esrc, logic [3:0] erdy);
    vec_t t;
    t.v = v; t.r = r; t.evld = evld; t.esrc = esrc; t.erdy = erdy;
    return t;
  endfunction

  function automatic logic [17:0] etag(int s);
    logic [1:0]  idx;
    logic [15:0] tg;
    idx = 2'(s);
    tg  = 16'h00A9 + 16'(s);
    return {idx, tg};
  endfunction

  function automatic logic [127:0] etex(int s);
    logic [31:0] w;
    w = 32'h1111_1111 * 32'(s ^ 3);
    return {w, w, w, w};
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [143:0] sb[$];
  logic [143:0] front;
  logic         pend, v1, in_f, out_f;

  initial begin
    for (int i = 0; i < 4; i++) begin
      bus.rsp_tag_in[i]    = 16'h00A9 + 16'(i);
      bus.rsp_texels_in[i] = etex(i);
    end
    bus.rsp_valid_in    = 4'b1111;
    bus.rsp_ready_out   = 1'b0;
    bus1.rsp_valid_in   = 1'b0;
    bus1.rsp_ready_out  = 1'b0;
    bus1.rsp_tag_in[0]  = '0;
    bus1.rsp_texels_in[0] = '0;

    tbl[0]  = mk(4'b1111, 1, 0, 0, 4'b0001);
    tbl[1]  = mk(4'b1111, 1, 1, 0, 4'b0010);
    tbl[2]  = mk(4'b1111, 1, 1, 1, 4'b0100);
    tbl[3]  = mk(4'b1111, 1, 1, 2, 4'b1000);
    tbl[4]  = mk(4'b1111, 1, 1, 3, 4'b0001);
    tbl[5]  = mk(4'b1111, 1, 1, 0, 4'b0010);
    tbl[6]  = mk(4'b1111, 1, 1, 1, 4'b0100);
    tbl[7]  = mk(4'b1111, 1, 1, 2, 4'b1000);
    tbl[8]  = mk(4'b0111, 1, 1, 3, 4'b0001);
    tbl[9]  = mk(4'b0110, 1, 1, 0, 4'b0010);
    tbl[10] = mk(4'b0100, 1, 1, 1, 4'b0100);
    tbl[11] = mk(4'b0000, 1, 1, 2, 4'b0000);
    tbl[12] = mk(4'b0001, 1, 0, 0, 4'b0001);
    tbl[13] = mk(4'b0000, 1, 1, 0, 4'b0000);
    tbl[14] = mk(4'b1010, 0, 0, 0, 4'b0010);
    tbl[15] = mk(4'b1000, 0, 1, 1, 4'b1000);
    tbl[16] = mk(4'b0010, 0, 1, 1, 4'b0000);
    tbl[17] = mk(4'b0010, 0, 1, 1, 4'b0000);
    tbl[18] = mk(4'b0010, 1, 1, 1, 4'b0000);
    tbl[19] = mk(4'b0010, 1, 1, 3, 4'b0010);
    tbl[20] = mk(4'b0001, 1, 1, 1, 4'b0001);
    tbl[21] = mk(4'b0000, 1, 1, 0, 4'b0000);
    tbl[22] = mk(4'b0000, 1, 0, 0, 4'b0000);
    tbl[23] = mk(4'b0100, 1, 0, 0, 4'b0100);
    tbl[24] = mk(4'b0000, 1, 1, 2, 4'b0000);
    tbl[25] = mk(4'b0000, 0, 0, 0, 4'b0000);

    // Reset state with sources already valid
    #1;
    chk("rst_vld", 144'(bus.rsp_valid_out), 144'(0));
    chk("rst_rdy", 144'(bus.rsp_ready_in), 144'(0));
    chk("rst_tag", 144'(bus.rsp_tag_out), 144'(0));
    chk("rst_tex", 144'(bus.rsp_texels_out), 144'(0));
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[k]) begin
      bus.rsp_valid_in  = tbl[k].v;
      bus.rsp_ready_out = tbl[k].r;
      #1;
      chk($sformatf("r%0d_vld", k), 144'(bus.rsp_valid_out), 144'(tbl[k].evld));
      chk($sformatf("r%0d_rdy", k), 144'(bus.rsp_ready_in), 144'(tbl[k].erdy));
      if (tbl[k].evld) begin
        chk($sformatf("r%0d_tag", k), 144'(bus.rsp_tag_out), 144'(etag(tbl[k].esrc)));
        chk($sformatf("r%0d_tex", k), 144'(bus.rsp_texels_out), 144'(etex(tbl[k].esrc)));
      end
      @(posedge clk);
      #1;
    end

    // Fill both entries (pointer is at 3), then reset mid-traffic
    bus.rsp_valid_in  = 4'b1111;
    bus.rsp_ready_out = 1'b0;
    #1;
    chk("mr_rdy0", 144'(bus.rsp_ready_in), 144'(4'b1000));
    @(posedge clk); #1;
    chk("mr_tag1", 144'(bus.rsp_tag_out), 144'(etag(3)));
    chk("mr_rdy1", 144'(bus.rsp_ready_in), 144'(4'b0001));
    @(posedge clk); #1;
    chk("mr_full", 144'(bus.rsp_ready_in), 144'(0));
    chk("mr_tag2", 144'(bus.rsp_tag_out), 144'(etag(3)));
    reset = 1'b0;
    #1;
    chk("mr_async_vld", 144'(bus.rsp_valid_out), 144'(0));
    chk("mr_async_rdy", 144'(bus.rsp_ready_in), 144'(0));
    chk("mr_async_tag", 144'(bus.rsp_tag_out), 144'(0));
    @(posedge clk); #1;
    chk("mr_hold_vld", 144'(bus.rsp_valid_out), 144'(0));
    chk("mr_hold_rdy", 144'(bus.rsp_ready_in), 144'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mr_rel_rdy", 144'(bus.rsp_ready_in), 144'(4'b0001));
    chk("mr_rel_vld", 144'(bus.rsp_valid_out), 144'(0));
    @(posedge clk); #1;
    chk("mr_first_vld", 144'(bus.rsp_valid_out), 144'(1));
    chk("mr_first_tag", 144'(bus.rsp_tag_out), 144'(etag(0)));

    // Single-source build: random traffic against a scoreboard
    pend = 1'b0;
    v1   = 1'b0;
    for (int c = 0; c < 1020; c++) begin
      if (!pend) begin
        v1 = (c < 1000) && ($urandom_range(0, 3) != 0);
        if (v1) begin
          bus1.rsp_tag_in[0] = 16'($urandom);
          for (int l = 0; l < 4; l++) bus1.rsp_texels_in[0][l] = $urandom;
        end
      end
      bus1.rsp_valid_in[0] = v1;
      bus1.rsp_ready_out   = (c >= 1000) || ($urandom_range(0, 3) != 0);
      #1;
      in_f  = bus1.rsp_valid_in[0] & bus1.rsp_ready_in[0];
      out_f = bus1.rsp_valid_out & bus1.rsp_ready_out;
      if (out_f) begin
        if (sb.size() == 0) chk("n1_underflow", 144'(sb.size()), 144'(1));
        else begin
          front = sb.pop_front();
          chk($sformatf("n1_data_c%0d", c), {bus1.rsp_tag_out, bus1.rsp_texels_out}, front);
        end
      end
      if (in_f) sb.push_back({bus1.rsp_tag_in[0], bus1.rsp_texels_in[0]});
      pend = v1 & ~in_f;
      @(posedge clk); #1;
    end
    chk("n1_drained", 144'(sb.size()), 144'(0));
    chk("n1_idle_vld", 144'(bus1.rsp_valid_out), 144'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
